posit_add_checker: RTL and testbench

POSIT_ADD_CHECKER -- requirements
Module: posit_add_checker

---
 rtl/posit_add_checker.sv | 164 ++++++++++++++++
 tb/tb_posit_add_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/posit_add_checker.sv
// Statistics checker for a posit adder: compares DUT results against golden values,
// classifies the error magnitude and checks the inf/zero flags over a run of samples.
module posit_add_checker #(
    parameter int N  = 8,
    parameter int CW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [N-1:0]  dut_out,
    input  logic [N-1:0]  exp_out,
    input  logic          dut_inf,
    input  logic          dut_zero,
    input  logic          last,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] n_samples,
    output logic [CW-1:0] n_exact,
    output logic [CW-1:0] n_ulp1,
    output logic [CW-1:0] n_big,
    output logic [CW-1:0] n_flag_err,
    output logic [N-1:0]  max_diff,
    output logic [CW-1:0] max_idx,
    output logic [CW+N-1:0] sum_diff,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [N-1:0] INF_PAT = {1'b1, {(N-1){1'b0}}};

    state_t          state_q, state_d;
    logic            flush_cnt_q, flush_cnt_d;
    logic            s1_valid_q, s1_valid_d;
    logic [N-1:0]    s1_diff_q, s1_diff_d;
    logic            s1_flag_q, s1_flag_d;
    logic [CW-1:0]   n_samples_q, n_samples_d;
    logic [CW-1:0]   n_exact_q, n_exact_d;
    logic [CW-1:0]   n_ulp1_q, n_ulp1_d;
    logic [CW-1:0]   n_big_q, n_big_d;
    logic [CW-1:0]   n_flag_err_q, n_flag_err_d;
    logic [N-1:0]    max_diff_q, max_diff_d;
    logic [CW-1:0]   max_idx_q, max_idx_d;
    logic [CW+N-1:0] sum_diff_q, sum_diff_d;

    logic            accept;
    logic [N-1:0]    diff;
    logic            flag_err;
    logic [CW+N:0]   sum_ext;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A start in the same cycle wins over the sample, so it is not accepted.
    assign accept   = (state_q == S_RUN) && in_valid && !start;
    assign diff     = (exp_out >= dut_out) ? (exp_out - dut_out) : (dut_out - exp_out);
    assign flag_err = (dut_inf != (dut_out == INF_PAT)) || (dut_zero != (dut_out == '0));
    assign sum_ext  = {1'b0, sum_diff_q} + (CW+N+1)'(s1_diff_q);

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        s1_valid_d   = accept;
        s1_diff_d    = diff;
        s1_flag_d    = flag_err;
        n_samples_d  = n_samples_q;
        n_exact_d    = n_exact_q;
        n_ulp1_d     = n_ulp1_q;
        n_big_d      = n_big_q;
        n_flag_err_d = n_flag_err_q;
        max_diff_d   = max_diff_q;
        max_idx_d    = max_idx_q;
        sum_diff_d   = sum_diff_q;

        case (state_q)
            S_RUN: begin
                if (accept && last) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = 1'b0;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q) state_d = S_DONE;
                else             flush_cnt_d = 1'b1;
            end
            default: ;
        endcase

        // Stage 2: the index of a sample is the sample count before it is added.
        if (s1_valid_q) begin
            n_samples_d = sat_inc(n_samples_q);
            if (s1_diff_q == '0)                 n_exact_d = sat_inc(n_exact_q);
            else if (s1_diff_q == N'(1))         n_ulp1_d  = sat_inc(n_ulp1_q);
            else                                 n_big_d   = sat_inc(n_big_q);
            if (s1_flag_q) n_flag_err_d = sat_inc(n_flag_err_q);
            if (s1_diff_q > max_diff_q) begin
                max_diff_d = s1_diff_q;
                max_idx_d  = n_samples_q;
            end
            sum_diff_d = sum_ext[CW+N] ? '1 : sum_ext[CW+N-1:0];
        end

        if (start) begin
            state_d      = S_RUN;
            flush_cnt_d  = 1'b0;
            s1_valid_d   = 1'b0;
            n_samples_d  = '0;
            n_exact_d    = '0;
            n_ulp1_d     = '0;
            n_big_d      = '0;
            n_flag_err_d = '0;
            max_diff_d   = '0;
            max_idx_d    = '0;
            sum_diff_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            flush_cnt_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_diff_q    <= '0;
            s1_flag_q    <= 1'b0;
            n_samples_q  <= '0;
            n_exact_q    <= '0;
            n_ulp1_q     <= '0;
            n_big_q      <= '0;
            n_flag_err_q <= '0;
            max_diff_q   <= '0;
            max_idx_q    <= '0;
            sum_diff_q   <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_diff_q    <= s1_diff_d;
            s1_flag_q    <= s1_flag_d;
            n_samples_q  <= n_samples_d;
            n_exact_q    <= n_exact_d;
            n_ulp1_q     <= n_ulp1_d;
            n_big_q      <= n_big_d;
            n_flag_err_q <= n_flag_err_d;
            max_diff_q   <= max_diff_d;
            max_idx_q    <= max_idx_d;
            sum_diff_q   <= sum_diff_d;
        end
    end

    assign busy       = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done       = (state_q == S_DONE);
    assign state_dbg  = state_q;
    assign n_samples  = n_samples_q;
    assign n_exact    = n_exact_q;
    assign n_ulp1     = n_ulp1_q;
    assign n_big      = n_big_q;
    assign n_flag_err = n_flag_err_q;
    assign max_diff   = max_diff_q;
    assign max_idx    = max_idx_q;
    assign sum_diff   = sum_diff_q;

endmodule

// File: tb/tb_posit_add_checker.sv
// Directed bench for posit_add_checker: a default instance plus a CW=4 instance
// sharing the same stimulus for the saturation scenario.
module tb_posit_add_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  dut_out = '0;
    logic [7:0]  exp_out = '0;
    logic        dut_inf = 1'b0;
    logic        dut_zero = 1'b0;
    logic        last = 1'b0;

    logic        busy, done;
    logic [16:0] n_samples, n_exact, n_ulp1, n_big, n_flag_err, max_idx;
    logic [7:0]  max_diff;
    logic [24:0] sum_diff;
    logic [1:0]  state_dbg;

    logic        s_busy, s_done;
    logic [3:0]  s_n_samples, s_n_exact, s_n_ulp1, s_n_big, s_n_flag_err, s_max_idx;
    logic [7:0]  s_max_diff;
    logic [11:0] s_sum_diff;
    logic [1:0]  s_state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    posit_add_checker #(.N(8), .CW(17)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .dut_out(dut_out), .exp_out(exp_out), .dut_inf(dut_inf), .dut_zero(dut_zero),
        .last(last), .busy(busy), .done(done), .n_samples(n_samples), .n_exact(n_exact),
        .n_ulp1(n_ulp1), .n_big(n_big), .n_flag_err(n_flag_err), .max_diff(max_diff),
        .max_idx(max_idx), .sum_diff(sum_diff), .state_dbg(state_dbg)
    );

    posit_add_checker #(.N(8), .CW(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .dut_out(dut_out), .exp_out(exp_out), .dut_inf(dut_inf), .dut_zero(dut_zero),
        .last(last), .busy(s_busy), .done(s_done), .n_samples(s_n_samples), .n_exact(s_n_exact),
        .n_ulp1(s_n_ulp1), .n_big(s_n_big), .n_flag_err(s_n_flag_err), .max_diff(s_max_diff),
        .max_idx(s_max_idx), .sum_diff(s_sum_diff), .state_dbg(s_state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] e, input logic inf,
                        input logic zero, input logic lst);
        dut_out = d; exp_out = e; dut_inf = inf; dut_zero = zero; last = lst; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b exp 00", {busy, done}); end
        checks++; if (n_samples !== 17'd0 || sum_diff !== 25'd0 || max_diff !== 8'd0) begin
            errors++; $display("FAIL reset_stats got n=%0d sum=%0d max=%0d exp 0", n_samples, sum_diff, max_diff); end
        rst = 1'b0;
        send(8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        checks++; if (state_dbg !== 2'd0 || n_samples !== 17'd0) begin
            errors++; $display("FAIL idle_ignores_input got state=%0d n=%0d exp 0/0", state_dbg, n_samples); end
    endtask

    task automatic test_basic();
        pulse_start();
        checks++; if (state_dbg !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL basic_run got state=%0d busy=%b exp 1/1", state_dbg, busy); end
        send(8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
        checks++; if (n_samples !== 17'd0) begin errors++; $display("FAIL basic_latency1 got %0d exp 0", n_samples); end
        send(8'h11, 8'h10, 1'b0, 1'b0, 1'b0);
        checks++; if (n_samples !== 17'd1) begin errors++; $display("FAIL basic_latency2 got %0d exp 1", n_samples); end
        send(8'h20, 8'h10, 1'b0, 1'b0, 1'b0);
        send(8'h0F, 8'h10, 1'b0, 1'b0, 1'b1);
        checks++; if (state_dbg !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL basic_flush got state=%0d busy=%b exp 2/1", state_dbg, busy); end
        tick();
        checks++; if (done !== 1'b0 || n_samples !== 17'd4) begin errors++; $display("FAIL basic_flush2 got done=%b n=%0d exp 0/4", done, n_samples); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done got done=%b busy=%b exp 1/0", done, busy); end
        checks++; if (n_exact !== 17'd1 || n_ulp1 !== 17'd2 || n_big !== 17'd1) begin
            errors++; $display("FAIL basic_classes got %0d/%0d/%0d exp 1/2/1", n_exact, n_ulp1, n_big); end
        checks++; if (max_diff !== 8'h10 || max_idx !== 17'd2) begin errors++; $display("FAIL basic_max got %h@%0d exp 10@2", max_diff, max_idx); end
        checks++; if (sum_diff !== 25'd18) begin errors++; $display("FAIL basic_sum got %0d exp 18", sum_diff); end
        checks++; if (n_flag_err !== 17'd0) begin errors++; $display("FAIL basic_flags got %0d exp 0", n_flag_err); end
        send(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        send(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (done !== 1'b1 || n_samples !== 17'd4 || sum_diff !== 25'd18) begin
            errors++; $display("FAIL done_hold got done=%b n=%0d sum=%0d exp 1/4/18", done, n_samples, sum_diff); end
    endtask

    task automatic test_flags();
        pulse_start();
        checks++; if (n_samples !== 17'd0 || sum_diff !== 25'd0) begin errors++; $display("FAIL restart_clear got n=%0d sum=%0d exp 0/0", n_samples, sum_diff); end
        send(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        send(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        tick(); tick();
        checks++; if (done !== 1'b1 || n_flag_err !== 17'd1) begin errors++; $display("FAIL flags_count got done=%b ferr=%0d exp 1/1", done, n_flag_err); end
        checks++; if (n_exact !== 17'd2) begin errors++; $display("FAIL flags_exact got %0d exp 2", n_exact); end
    endtask

    task automatic test_ties();
        pulse_start();
        send(8'h05, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
        last = 1'b1;
        tick();
        last = 1'b0;
        checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL last_no_valid got state=%0d exp 1", state_dbg); end
        checks++; if (max_diff !== 8'd5 || max_idx !== 17'd0 || n_samples !== 17'd2) begin
            errors++; $display("FAIL ties_keep got %0d@%0d n=%0d exp 5@0 n=2", max_diff, max_idx, n_samples); end
        send(8'h0A, 8'h10, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        checks++; if (done !== 1'b1 || max_diff !== 8'd6 || max_idx !== 17'd2) begin
            errors++; $display("FAIL ties_update got done=%b %0d@%0d exp 1 6@2", done, max_diff, max_idx); end
    endtask

    task automatic test_start_mid_run();
        pulse_start();
        send(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        dut_out = 8'h07; exp_out = 8'h00; in_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        checks++; if (n_samples !== 17'd0 || sum_diff !== 25'd0 || max_diff !== 8'd0 || state_dbg !== 2'd1) begin
            errors++; $display("FAIL midstart_clear got n=%0d sum=%0d max=%0d st=%0d exp 0/0/0/1", n_samples, sum_diff, max_diff, state_dbg); end
        tick();
        checks++; if (n_samples !== 17'd0 || sum_diff !== 25'd0) begin errors++; $display("FAIL midstart_later got n=%0d sum=%0d exp 0/0", n_samples, sum_diff); end
        send(8'h03, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        checks++; if (done !== 1'b1 || n_samples !== 17'd1 || sum_diff !== 25'd3 || max_idx !== 17'd0 || max_diff !== 8'd3) begin
            errors++; $display("FAIL midstart_resume got done=%b n=%0d sum=%0d max=%0d@%0d exp 1/1/3 3@0", done, n_samples, sum_diff, max_diff, max_idx); end
    endtask

    task automatic test_saturation();
        pulse_start();
        for (int i = 0; i < 20; i++) send(8'h33, 8'h33, 1'b0, 1'b0, (i == 19));
        tick(); tick();
        checks++; if (s_done !== 1'b1 || s_n_samples !== 4'd15 || s_n_exact !== 4'd15) begin
            errors++; $display("FAIL sat_counts got done=%b n=%0d ex=%0d exp 1/15/15", s_done, s_n_samples, s_n_exact); end
        checks++; if (s_n_ulp1 !== 4'd0 || s_sum_diff !== 12'd0) begin errors++; $display("FAIL sat_other got ulp1=%0d sum=%0d exp 0/0", s_n_ulp1, s_sum_diff); end
        checks++; if (n_samples !== 17'd20) begin errors++; $display("FAIL wide_count got %0d exp 20", n_samples); end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        send(8'h04, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h05, 8'h00, 1'b0, 1'b0, 1'b0);
        dut_out = 8'h06; exp_out = 8'h00; in_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (state_dbg !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_state got st=%0d busy=%b done=%b exp 0/0/0", state_dbg, busy, done); end
        checks++; if (n_samples !== 17'd0 || sum_diff !== 25'd0 || max_diff !== 8'd0 || n_big !== 17'd0) begin
            errors++; $display("FAIL midrst_stats got n=%0d sum=%0d max=%0d big=%0d exp 0", n_samples, sum_diff, max_diff, n_big); end
        tick(); tick();
        checks++; if (n_samples !== 17'd0 || state_dbg !== 2'd0) begin errors++; $display("FAIL midrst_later got n=%0d st=%0d exp 0/0", n_samples, state_dbg); end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_flags();
        test_ties();
        test_start_mid_run();
        test_saturation();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
